// File: rtl/alu_pkg.sv
// Opcodes and state encoding shared between the ALU decode and the
// multi-cycle multiply sequencer.
package alu_pkg;

  localparam logic [5:0] OP_MULTU = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b010100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Radix-2 shift-add multiplier for MULTU/MULT. Takes WIDTH+1 cycles per
// product and returns the result as lo/hi words with zero and sign flags.
module mul_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [5:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             z_flag,
  output logic             s_flag,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  logic [WIDTH:0]     acc_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic               neg_reg;
  logic               is_mul_reg;

  logic               accept;
  logic               op_multu;
  logic               op_mult;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] p_signed;

  // Two's-complement magnitude; the most negative value maps to itself,
  // which is still correct when read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  assign start_ready = rst_n && (state_reg == IDLE);
  assign accept      = start_valid && start_ready;
  assign op_multu    = (control == OP_MULTU);
  assign op_mult     = (control == OP_MULT);

  assign sum      = acc_reg + {1'b0, (mplier_reg[0] ? mcand_reg : '0)};
  assign prod     = {acc_reg[WIDTH-1:0], mplier_reg};
  assign p_signed = neg_reg ? (~prod + (2*WIDTH)'(1)) : prod;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = (op_multu || op_mult) ? BUSY : FIX;
      BUSY: if (cnt_reg == LAST_CNT) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      mcand_reg  <= '0;
      neg_reg    <= 1'b0;
      is_mul_reg <= 1'b0;
      done       <= 1'b0;
      lo         <= '0;
      hi         <= '0;
      z_flag     <= 1'b0;
      s_flag     <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_reg <= state_next;
      done      <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            is_mul_reg <= op_multu || op_mult;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            if (op_mult) begin
              mcand_reg  <= mag(a);
              mplier_reg <= mag(b);
              neg_reg    <= a[WIDTH-1] ^ b[WIDTH-1];
            end else begin
              mcand_reg  <= a;
              mplier_reg <= b;
              neg_reg    <= 1'b0;
            end
          end
        end
        BUSY: begin
          // {acc, mplier} <= {sum, mplier} >> 1
          acc_reg    <= {1'b0, sum[WIDTH:1]};
          mplier_reg <= {sum[0], mplier_reg[WIDTH-1:1]};
          cnt_reg    <= cnt_reg + CW'(1);
        end
        FIX: begin
          done <= 1'b1;
          if (is_mul_reg) begin
            lo     <= p_signed[WIDTH-1:0];
            hi     <= p_signed[2*WIDTH-1:WIDTH];
            z_flag <= (p_signed == '0);
            s_flag <= p_signed[2*WIDTH-1];
            err    <= 1'b0;
          end else begin
            lo     <= '0;
            hi     <= '0;
            z_flag <= 1'b1;
            s_flag <= 1'b0;
            err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: expected products are queued at accept
// and compared when done pulses.
module tb_mul_seq_ctrl;

  localparam logic [5:0] C_MULTU = 6'b010011;
  localparam logic [5:0] C_MULT  = 6'b010100;
  localparam logic [5:0] C_BAD   = 6'b010010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [5:0]  control;
  logic [31:0] a;
  logic [31:0] b;
  logic        done;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        z_flag;
  logic        s_flag;
  logic        err;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        s;
    logic        err;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  mul_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .control(control), .a(a), .b(b), .done(done), .lo(lo), .hi(hi),
    .z_flag(z_flag), .s_flag(s_flag), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference product computed with 64-bit arithmetic on sign/zero-extended operands.
  function automatic void push(input logic [5:0] c, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    if (c == C_MULTU) begin
      p = {32'b0, x} * {32'b0, y};
      e.err = 1'b0;
    end else if (c == C_MULT) begin
      p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
      e.err = 1'b0;
    end else begin
      p = 64'd0;
      e.err = 1'b1;
    end
    e.lo = p[31:0];
    e.hi = p[63:32];
    e.z = (p == 64'd0);
    e.s = p[63];
    e.acc_cyc = cyc + 1;
    e.chk_lat = (c == C_MULTU) || (c == C_MULT);
    sb.push_back(e);
    $display("req  ctrl=%b a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h", c, x, y, e.hi, e.lo);
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        $display("done hi=0x%08h lo=0x%08h z=%b s=%b err=%b", hi, lo, z_flag, s_flag, err);
        check("lo", lo, mon_e.lo);
        check("hi", hi, mon_e.hi);
        check("z_flag", z_flag, mon_e.z);
        check("s_flag", s_flag, mon_e.s);
        check("err", err, mon_e.err);
        if (mon_e.chk_lat) check("latency", cyc - mon_e.acc_cyc, 33);
      end
    end
  end

  task automatic send(input logic [5:0] c, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    @(negedge clk);
    start_valid = 1'b1; control = c; a = x; b = y;
    while (!start_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!start_ready) check("ready_timeout", 0, 1);
    push(c, x, y);
    @(posedge clk);
    #1 start_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1 check("drain", sb.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_lo"}, lo, 0);
    check({tag, "_hi"}, hi, 0);
    check({tag, "_z"}, z_flag, 0);
    check({tag, "_s"}, s_flag, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; start_valid = 1'b0; control = 6'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    check("reset_ready", start_ready, 0);
    rst_n = 1'b1;
    #1 check("release_ready", start_ready, 1);

    send(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    drain();
    send(C_MULT, 32'hFFFFFFFD, 32'd7);
    drain();
    send(C_MULT, 32'h80000000, 32'd1);
    drain();
    send(C_MULT, 32'h80000000, 32'h80000000);
    drain();
    send(C_MULT, 32'd0, 32'hFFFFFFFB);
    drain();
    send(C_MULT, 32'h7FFFFFFF, 32'h80000001);
    drain();

    // Requests during BUSY are ignored; a new one in the done cycle is taken.
    @(negedge clk);
    start_valid = 1'b1; control = C_MULTU; a = 32'h00001234; b = 32'h00005678;
    push(C_MULTU, a, b);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
      check("busy_ready", start_ready, 0);
    end
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done_seen", done, 1);
    check("b2b_ready", start_ready, 1);
    a = 32'd6; b = 32'd7;
    push(C_MULTU, a, b);
    @(posedge clk);
    #1 start_valid = 1'b0;
    drain();

    send(C_BAD, 32'd5, 32'd9);
    drain();
    send(C_MULTU, 32'd2, 32'd3);
    drain();

    // Reset in the middle of an iteration discards the operation.
    send(C_MULTU, 32'hDEADBEEF, 32'h12345678);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_zero_outputs("midreset");
    check("midreset_ready", start_ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrelease_ready", start_ready, 1);
    repeat (40) @(negedge clk);
    check_zero_outputs("postreset");
    send(C_MULTU, 32'd3, 32'd5);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
